// File: rtl/lsu_bus_if.sv
// Word-wide valid/ready data bus between the load/store bridge (master) and memory (slave).
// Read data is returned in the same cycle that bus_ready is high.
interface lsu_bus_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// MEM-stage load/store bridge: turns decoded loads/stores into one or two aligned bus beats.
// Optional macro LSU_MISALIGN_EN enables the two-beat word-crossing path; otherwise crossings are dropped.
module lsu_bus_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  lwhb,
    input  logic [1:0]  swhb,
    input  logic        lunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign_err,
    lsu_bus_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  size_reg;
    logic        unsigned_reg;
    logic        store_reg;
    logic        cross_reg;
    logic        err_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;

    logic        store_go;
    logic        go;
    logic [2:0]  req_size;
    logic        req_cross;
    logic [1:0]  off;
    logic [3:0]  byte_mask;
    logic [7:0]  strb8;
    logic [63:0] wd64;
    logic [31:0] rd_word;
    logic [31:0] load_ext;

    function automatic logic [31:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 32'h0000_00FF;
            3'd2:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // A store with swhb == 00 is a no-op and does not compete with a load.
    assign store_go = req_store && (swhb != 2'b00);
    assign go       = store_go || req_load;

    always_comb begin
        req_size = 3'd4;
        if (store_go) begin
            case (swhb)
                2'b10:   req_size = 3'd2;
                2'b11:   req_size = 3'd1;
                default: req_size = 3'd4;
            endcase
        end else begin
            case (lwhb)
                2'b01:   req_size = 3'd2;
                2'b10:   req_size = 3'd1;
                default: req_size = 3'd4;
            endcase
        end
    end

    assign req_cross = ({1'b0, addr[1:0]} + req_size) > 3'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            size_reg     <= 3'd4;
            unsigned_reg <= 1'b0;
            store_reg    <= 1'b0;
            cross_reg    <= 1'b0;
            err_reg      <= 1'b0;
            lo_reg       <= '0;
            hi_reg       <= '0;
        end else begin
            if (state_reg == ST_IDLE && go) begin
                addr_reg     <= addr;
                wdata_reg    <= wdata & size_mask(req_size);
                size_reg     <= req_size;
                unsigned_reg <= lunsigned;
                store_reg    <= store_go;
                cross_reg    <= req_cross;
`ifdef LSU_MISALIGN_EN
                err_reg      <= 1'b0;
`else
                err_reg      <= req_cross;
`endif
            end
            if (state_reg == ST_BEAT0 && bus.bus_ready) begin
                lo_reg <= bus.bus_rdata;
            end
            if (state_reg == ST_BEAT1 && bus.bus_ready) begin
                hi_reg <= bus.bus_rdata;
            end
        end
    end

    // Lane placement over a two-word window: low half feeds BEAT0, high half feeds BEAT1.
    assign off       = addr_reg[1:0];
    assign byte_mask = (size_reg == 3'd1) ? 4'b0001 :
                       (size_reg == 3'd2) ? 4'b0011 : 4'b1111;
    assign strb8     = {4'b0000, byte_mask} << off;
    assign wd64      = {32'd0, wdata_reg} << {off, 3'b000};
    assign rd_word   = 32'({hi_reg, lo_reg} >> {off, 3'b000});

    always_comb begin
        case (size_reg)
            3'd1:    load_ext = unsigned_reg ? {24'd0, rd_word[7:0]}
                                             : {{24{rd_word[7]}}, rd_word[7:0]};
            3'd2:    load_ext = unsigned_reg ? {16'd0, rd_word[15:0]}
                                             : {{16{rd_word[15]}}, rd_word[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        stall          = 1'b0;
        done           = 1'b0;
        rdata          = 32'd0;
        misalign_err   = 1'b0;
        bus.bus_valid  = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = 32'd0;
        bus.bus_wstrb  = 4'd0;
        bus.bus_wdata  = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                stall = go;
                if (go) begin
`ifdef LSU_MISALIGN_EN
                    state_next = ST_BEAT0;
`else
                    state_next = req_cross ? ST_DONE : ST_BEAT0;
`endif
                end
            end
            ST_BEAT0: begin
                stall         = 1'b1;
                bus.bus_valid = 1'b1;
                bus.bus_we    = store_reg;
                bus.bus_addr  = {addr_reg[31:2], 2'b00};
                bus.bus_wstrb = strb8[3:0];
                bus.bus_wdata = wd64[31:0];
                if (bus.bus_ready) begin
                    state_next = cross_reg ? ST_BEAT1 : ST_DONE;
                end
            end
            ST_BEAT1: begin
                stall         = 1'b1;
                bus.bus_valid = 1'b1;
                bus.bus_we    = store_reg;
                bus.bus_addr  = {addr_reg[31:2] + 30'd1, 2'b00};
                bus.bus_wstrb = strb8[7:4];
                bus.bus_wdata = wd64[63:32];
                if (bus.bus_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                misalign_err = err_reg;
                rdata        = (store_reg || err_reg) ? 32'd0 : load_ext;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: a scripted bus slave per access, hand-computed expectations.
module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  lwhb = 2'b00;
    logic [1:0]  swhb = 2'b00;
    logic        lunsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_err;

    lsu_bus_if bus_if ();

    lsu_bus_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .req_load     (req_load),
        .req_store    (req_store),
        .lwhb         (lwhb),
        .swhb         (swhb),
        .lunsigned    (lunsigned),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int failures = 0;

    int          nbeats, unstable, done_cyc, stall_cyc, done_abs;
    logic [31:0] done_rdata;
    logic        done_err;
    logic [31:0] b_addr  [0:1];
    logic [31:0] b_wdata [0:1];
    logic [3:0]  b_strb  [0:1];
    logic        b_we    [0:1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request, then plays the bus slave with w0/w1 wait cycles before each beat.
    task automatic access(input string name, input logic ld, input logic st,
                          input logic [1:0] lw, input logic [1:0] sw, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input int w0, input int w1);
        int beat = 0;
        int wcnt = 0;
        bit first = 1'b1;
        nbeats = 0; unstable = 0; done_cyc = -1; stall_cyc = 0;
        done_rdata = 32'd0; done_err = 1'b0; done_abs = -1;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 32'd0; b_wdata[i] = 32'd0; b_strb[i] = 4'd0; b_we[i] = 1'b0;
        end
        @(negedge clk);
        req_load = ld; req_store = st; lwhb = lw; swhb = sw; lunsigned = uns;
        addr = a; wdata = wd; bus_if.bus_ready = 1'b0;
        #1;
        if (stall) stall_cyc++;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            req_load = 1'b0; req_store = 1'b0;
            bus_if.bus_ready = (wcnt >= ((beat == 0) ? w0 : w1));
            bus_if.bus_rdata = (beat == 0) ? rd0 : rd1;
            #1;
            if (stall) stall_cyc++;
            if (bus_if.bus_valid && beat < 2) begin
                if (first) begin
                    b_addr[beat]  = bus_if.bus_addr;
                    b_wdata[beat] = bus_if.bus_wdata;
                    b_strb[beat]  = bus_if.bus_wstrb;
                    b_we[beat]    = bus_if.bus_we;
                end else if (b_addr[beat] !== bus_if.bus_addr || b_wdata[beat] !== bus_if.bus_wdata ||
                             b_strb[beat] !== bus_if.bus_wstrb || b_we[beat] !== bus_if.bus_we) begin
                    unstable++;
                end
                if (bus_if.bus_ready) begin
                    nbeats++; beat++; wcnt = 0; first = 1'b1;
                end else begin
                    wcnt++; first = 1'b0;
                end
            end
            if (done) begin
                done_cyc = n; done_rdata = rdata; done_err = misalign_err; done_abs = cyc_cnt;
                break;
            end
        end
        bus_if.bus_ready = 1'b0;
        $display("txn %s addr=%h beats=%0d done_cyc=%0d stall_cyc=%0d rdata=%h err=%0d",
                 name, a, nbeats, done_cyc, stall_cyc, done_rdata, done_err);
    endtask

    initial begin
        int first_done;
        int cnt_done;
        int cnt_valid;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", bus_if.bus_valid, 0);
        check_eq("rst_addr",  bus_if.bus_addr, 0);
        check_eq("rst_strb",  bus_if.bus_wstrb, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_err",   misalign_err, 0);
        check_eq("rst_stall", stall, 0);
        $display("txn reset valid=%0d done=%0d stall=%0d", bus_if.bus_valid, done, stall);
        @(negedge clk);
        reset = 1'b1;

        // Aligned word load
        access("lw", 1, 0, 2'b00, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);
        check_eq("lw_beats", nbeats, 1);
        check_eq("lw_addr",  b_addr[0], 32'h100);
        check_eq("lw_we",    b_we[0], 0);
        check_eq("lw_rdata", done_rdata, 32'hDEADBEEF);
        check_eq("lw_lat",   done_cyc, 2);
        check_eq("lw_stall", stall_cyc, 2);
        check_eq("lw_err",   done_err, 0);
        first_done = done_abs;

        // Back-to-back: next done exactly 3 cycles later
        access("lh", 1, 0, 2'b01, 2'b00, 0, 32'h102, 32'h0, 32'h80011234, 32'h0, 0, 0);
        check_eq("lh_rdata", done_rdata, 32'hFFFF8001);
        check_eq("b2b_gap",  done_abs - first_done, 3);

        // Byte loads with extension
        access("lb", 1, 0, 2'b10, 2'b00, 0, 32'h203, 32'h0, 32'h80112233, 32'h0, 0, 0);
        check_eq("lb_addr",  b_addr[0], 32'h200);
        check_eq("lb_rdata", done_rdata, 32'hFFFFFF80);
        access("lbu", 1, 0, 2'b10, 2'b00, 1, 32'h203, 32'h0, 32'h80112233, 32'h0, 0, 0);
        check_eq("lbu_rdata", done_rdata, 32'h00000080);

        // Half store with three wait states
        access("sh", 0, 1, 2'b00, 2'b10, 0, 32'h302, 32'h0000ABCD, 32'h0, 32'h0, 3, 0);
        check_eq("sh_addr",   b_addr[0], 32'h300);
        check_eq("sh_we",     b_we[0], 1);
        check_eq("sh_strb",   b_strb[0], 4'b1100);
        check_eq("sh_wdata",  b_wdata[0], 32'hABCD0000);
        check_eq("sh_stable", unstable, 0);
        check_eq("sh_lat",    done_cyc, 5);
        check_eq("sh_rdata",  done_rdata, 0);

        // Byte store; store wins when both requests are high
        access("sb", 1, 1, 2'b00, 2'b11, 0, 32'h601, 32'hFFFFFFAB, 32'h0, 32'h0, 0, 0);
        check_eq("sb_we",    b_we[0], 1);
        check_eq("sb_strb",  b_strb[0], 4'b0010);
        check_eq("sb_wdata", b_wdata[0], 32'h0000AB00);

        // Misaligned word load
        access("lw_mis", 1, 0, 2'b00, 2'b00, 0, 32'h401, 32'h0, 32'h44332211, 32'h88776655, 0, 0);
`ifdef LSU_MISALIGN_EN
        check_eq("mis_beats", nbeats, 2);
        check_eq("mis_addr0", b_addr[0], 32'h400);
        check_eq("mis_addr1", b_addr[1], 32'h404);
        check_eq("mis_rdata", done_rdata, 32'h55443322);
        check_eq("mis_lat",   done_cyc, 3);
        check_eq("mis_err",   done_err, 0);
`else
        check_eq("mis_beats", nbeats, 0);
        check_eq("mis_err",   done_err, 1);
        check_eq("mis_rdata", done_rdata, 0);
        check_eq("mis_lat",   done_cyc, 1);
`endif

        // Word store wrapping past the top of the address space
        access("sw_wrap", 0, 1, 2'b00, 2'b01, 0, 32'hFFFFFFFE, 32'h11223344, 32'h0, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_EN
        check_eq("wrap_beats",  nbeats, 2);
        check_eq("wrap_addr0",  b_addr[0], 32'hFFFFFFFC);
        check_eq("wrap_strb0",  b_strb[0], 4'b1100);
        check_eq("wrap_wdata0", b_wdata[0], 32'h33440000);
        check_eq("wrap_addr1",  b_addr[1], 32'h00000000);
        check_eq("wrap_strb1",  b_strb[1], 4'b0011);
        check_eq("wrap_wdata1", b_wdata[1], 32'h00001122);
`else
        check_eq("wrap_beats", nbeats, 0);
        check_eq("wrap_err",   done_err, 1);
        check_eq("wrap_lat",   done_cyc, 1);
`endif

        // Reset during BEAT0 with the bus stalled
        @(negedge clk);
        req_load = 1'b1; lwhb = 2'b00; addr = 32'h500; bus_if.bus_ready = 1'b0;
        @(negedge clk);
        req_load = 1'b0;
        #1;
        check_eq("rb0_valid", bus_if.bus_valid, 1);
        reset = 1'b0;
        #1;
        check_eq("rb0_drop", bus_if.bus_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        bus_if.bus_ready = 1'b1;
        cnt_done = 0; cnt_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done) cnt_done++;
            if (bus_if.bus_valid) cnt_valid++;
        end
        bus_if.bus_ready = 1'b0;
        check_eq("rb0_no_done",  cnt_done, 0);
        check_eq("rb0_no_valid", cnt_valid, 0);
        check_eq("rb0_idle",     stall, 0);
        $display("txn reset_beat0 done_seen=%0d valid_seen=%0d", cnt_done, cnt_valid);

        // Recovery after reset
        access("lw_after", 1, 0, 2'b11, 2'b00, 0, 32'h700, 32'h0, 32'h12345678, 32'h0, 0, 0);
        check_eq("after_rdata", done_rdata, 32'h12345678);
        check_eq("after_lat",   done_cyc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
